// File: rtl/iram_loader_if.sv
// Byte-stream input and IRAM write port of the instruction loader.
interface iram_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           wr_data;

  // Loader side: consumes bytes, drives the RAM write port.
  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  // Environment side: byte source and instruction RAM.
  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/iram_loader.sv
// Instruction RAM loader: takes COUNT, N big-endian word pairs and a checksum
// byte from a byte stream, writes the words to consecutive IRAM addresses and
// holds the CPU while loading.
module iram_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_start,
  iram_loader_if.master       bus,
  output logic                busy,
  output logic                cpu_hold,
  output logic                done,
  output logic [1:0]          error,
  output logic [ADDR_WIDTH:0] words_written
);
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_CHK
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             timeout_hit;
  logic [7:0]       csum;
  logic [7:0]       hi_byte;
  logic [8:0]       words_left;
  logic [TMO_W-1:0] tmo_cnt;

  // Modulo-256 running checksum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign bus.in_ready = (state != S_IDLE);
  assign busy         = (state != S_IDLE);
  assign cpu_hold     = busy;
  assign accept       = bus.in_valid && (state != S_IDLE);
  // Idle cycle that would bring the gap to TIMEOUT_CYCLES aborts the load.
  assign timeout_hit  = (state != S_IDLE) && !accept && (tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: one stream field per state, timeout overrides.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (load_start) state_nxt = S_COUNT;
      S_COUNT: if (accept)     state_nxt = S_HI;
      S_HI:    if (accept)     state_nxt = S_LO;
      S_LO:    if (accept)     state_nxt = (words_left == 9'd1) ? S_CHK : S_HI;
      S_CHK:   if (accept)     state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
    if (timeout_hit) state_nxt = S_IDLE;
  end

  // Word assembly, write strobe, checksum, timeout counter and status.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      done          <= 1'b0;
      error         <= 2'b00;
      words_written <= '0;
      csum          <= '0;
      hi_byte       <= '0;
      words_left    <= '0;
      tmo_cnt       <= '0;
    end else begin
      done      <= 1'b0;
      bus.wr_en <= 1'b0;
      // Address and count advance once the write cycle has been presented.
      if (bus.wr_en) begin
        bus.wr_addr   <= bus.wr_addr + 1'b1;
        words_written <= words_written + 1'b1;
      end
      if (state != S_IDLE) begin
        if (accept)           tmo_cnt <= '0;
        else if (timeout_hit) begin
          tmo_cnt <= '0;
          error   <= 2'b10;
        end else              tmo_cnt <= tmo_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (load_start) begin
            error         <= 2'b00;
            words_written <= '0;
            csum          <= '0;
            tmo_cnt       <= '0;
            bus.wr_addr   <= BASE;
          end
        end
        S_COUNT: begin
          if (accept) begin
            csum       <= bus.in_data;
            words_left <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
          end
        end
        S_HI: begin
          if (accept) begin
            hi_byte <= bus.in_data;
            csum    <= csum_add(csum, bus.in_data);
          end
        end
        S_LO: begin
          if (accept) begin
            csum        <= csum_add(csum, bus.in_data);
            bus.wr_data <= {hi_byte, bus.in_data};
            bus.wr_en   <= 1'b1;
            words_left  <= words_left - 1'b1;
          end
        end
        S_CHK: begin
          if (accept) begin
            if (bus.in_data == csum) done  <= 1'b1;
            else                     error <= 2'b01;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iram_loader.sv
// Bench for iram_loader: two instances (base 0x00 and 0xFE) share one byte
// stream; a reference model predicts writes and load outcomes into queues
// that per-instance negedge monitors drain.
module tb_iram_loader;
  typedef logic [7:0] bq_t[$];

  localparam int BASE0 = 0;
  localparam int BASE1 = 8'hFE;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 0;

  iram_loader_if #(.ADDR_WIDTH(8)) bus0 ();
  iram_loader_if #(.ADDR_WIDTH(8)) bus1 ();

  assign bus0.in_data  = in_data;
  assign bus0.in_valid = in_valid;
  assign bus1.in_data  = in_data;
  assign bus1.in_valid = in_valid;

  logic       busy_w[2];
  logic       hold_w[2];
  logic       done_w[2];
  logic [1:0] err_w[2];
  logic [8:0] ww_w[2];
  logic       wr_en_w[2];
  logic       rdy_w[2];
  logic [7:0] wr_addr_w[2];
  logic [15:0] wr_data_w[2];

  assign wr_en_w[0]   = bus0.wr_en;
  assign wr_en_w[1]   = bus1.wr_en;
  assign rdy_w[0]     = bus0.in_ready;
  assign rdy_w[1]     = bus1.in_ready;
  assign wr_addr_w[0] = bus0.wr_addr;
  assign wr_addr_w[1] = bus1.wr_addr;
  assign wr_data_w[0] = bus0.wr_data;
  assign wr_data_w[1] = bus1.wr_data;

  iram_loader #(.ADDR_WIDTH(8), .BASE_ADDR(BASE0), .TIMEOUT_CYCLES(16)) u_dut0 (
    .clock(clock), .reset(reset), .load_start(load_start), .bus(bus0),
    .busy(busy_w[0]), .cpu_hold(hold_w[0]), .done(done_w[0]),
    .error(err_w[0]), .words_written(ww_w[0])
  );

  iram_loader #(.ADDR_WIDTH(8), .BASE_ADDR(BASE1), .TIMEOUT_CYCLES(16)) u_dut1 (
    .clock(clock), .reset(reset), .load_start(load_start), .bus(bus1),
    .busy(busy_w[1]), .cpu_hold(hold_w[1]), .done(done_w[1]),
    .error(err_w[1]), .words_written(ww_w[1])
  );

  initial forever #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard queues: write entries {addr, data}, outcome entries {done, error, words}.
  logic [23:0] exp_wr0[$];
  logic [23:0] exp_wr1[$];
  logic [11:0] exp_oc0[$];
  logic [11:0] exp_oc1[$];

  function automatic void chk(input string name, input int k, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endfunction

  function automatic int wr_size(input int k);
    return (k == 0) ? exp_wr0.size() : exp_wr1.size();
  endfunction
  function automatic logic [23:0] wr_pop(input int k);
    if (k == 0) return exp_wr0.pop_front();
    return exp_wr1.pop_front();
  endfunction
  function automatic int oc_size(input int k);
    return (k == 0) ? exp_oc0.size() : exp_oc1.size();
  endfunction
  function automatic logic [11:0] oc_pop(input int k);
    if (k == 0) return exp_oc0.pop_front();
    return exp_oc1.pop_front();
  endfunction

  // Reference model: derive writes and outcome from the byte list alone.
  task automatic expect_load(input bq_t b, input bit aborted);
    int n;
    int pairs;
    int sum;
    logic [15:0] d;
    logic [11:0] oc;
    n = (b[0] == 8'd0) ? 256 : int'(b[0]);
    pairs = (b.size() - 1) / 2;
    if (pairs > n) pairs = n;
    for (int i = 0; i < pairs; i++) begin
      d = {b[1 + 2 * i], b[2 + 2 * i]};
      exp_wr0.push_back({8'((BASE0 + i) % 256), d});
      exp_wr1.push_back({8'((BASE1 + i) % 256), d});
    end
    if (aborted) oc = 12'h000;
    else if (b.size() == 2 * n + 2) begin
      sum = 0;
      for (int i = 0; i <= 2 * n; i++) sum += int'(b[i]);
      if ((sum % 256) == int'(b[2 * n + 1])) oc = {1'b1, 2'b00, 9'(n)};
      else                                   oc = {1'b0, 2'b01, 9'(n)};
    end else oc = {1'b0, 2'b10, 9'(pairs)};
    exp_oc0.push_back(oc);
    exp_oc1.push_back(oc);
  endtask

  // Monitors: writes against the write queue, load end against the outcome queue.
  logic [11:0] e_oc;
  logic [23:0] e_wr;
  logic [8:0]  ww_exp[2];
  bit          ww_pend[2];
  bit          prev_busy[2];

  always @(negedge clock) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("cpu_hold", k, hold_w[k], busy_w[k]);
        if (wr_en_w[k]) begin
          if (wr_size(k) == 0) chk("unexpected_write", k, wr_addr_w[k], 32'hFFFF_FFFF);
          else begin
            e_wr = wr_pop(k);
            chk("wr_addr", k, wr_addr_w[k], e_wr[23:16]);
            chk("wr_data", k, wr_data_w[k], e_wr[15:0]);
          end
        end
        if (ww_pend[k]) begin
          chk("words_written", k, ww_w[k], ww_exp[k]);
          ww_pend[k] = 0;
        end
        if (prev_busy[k] && !busy_w[k]) begin
          if (oc_size(k) == 0) chk("unexpected_end", k, {done_w[k], err_w[k]}, 32'hFFFF_FFFF);
          else begin
            e_oc = oc_pop(k);
            chk("done", k, done_w[k], e_oc[11]);
            chk("error", k, err_w[k], e_oc[10:9]);
            ww_exp[k]  = e_oc[8:0];
            ww_pend[k] = 1;
          end
        end else if (done_w[k]) chk("stray_done", k, done_w[k], 0);
        prev_busy[k] = busy_w[k];
      end
    end
  end

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clock); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    in_valid = 1'b1;
    in_data  = b;
    got = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (rdy_w[0]) begin got = 1; break; end
    end
    chk("handshake", 0, got, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input bq_t b, input int gapmax);
    foreach (b[i]) send_byte(b[i], (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (!busy_w[0]) begin idle = 1; break; end
    end
    chk("load_end", 0, idle, 1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    bq_t b;
    int  n;
    int  sum;
    int  cyc;
    logic [7:0] x;

    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, busy_w[k], 0);
      chk("rst_done", k, done_w[k], 0);
      chk("rst_error", k, err_w[k], 0);
      chk("rst_words", k, ww_w[k], 0);
      chk("rst_wr_en", k, wr_en_w[k], 0);
      chk("rst_wr_addr", k, wr_addr_w[k], 0);
      chk("rst_wr_data", k, wr_data_w[k], 0);
      chk("rst_in_ready", k, rdy_w[k], 0);
    end
    @(posedge clock); #1;
    reset  = 1'b0;
    mon_en = 1;
    @(posedge clock); #1;

    // Basic load, then the same stream with a bad checksum.
    b = '{8'h02, 8'hC0, 8'hFF, 8'h31, 8'h02, 8'hF4};
    start_load(); expect_load(b, 0); send_stream(b, 0); wait_idle();
    b = '{8'h02, 8'hC0, 8'hFF, 8'h31, 8'h02, 8'hF5};
    start_load(); expect_load(b, 0); send_stream(b, 0); wait_idle();
    chk("error_sticky", 0, err_w[0], 2'b01);

    // Timeout after COUNT and one HI byte.
    b = '{8'h01, 8'h12};
    start_load(); expect_load(b, 0); send_stream(b, 0);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!busy_w[0]) break;
      cyc++;
    end
    chk("timeout_cycles", 0, cyc, 16);
    @(posedge clock); #1;
    chk("timeout_error", 0, err_w[0], 2'b10);

    // New load clears the error; stalled source with gaps.
    start_load();
    @(negedge clock);
    chk("error_cleared", 0, err_w[0], 2'b00);
    chk("error_cleared", 1, err_w[1], 2'b00);
    @(posedge clock); #1;
    b = '{8'h01, 8'h12, 8'h34, 8'h47};
    expect_load(b, 0); send_stream(b, 5); wait_idle();

    // Reset in the middle of a load.
    b = '{8'h02, 8'hAB, 8'hCD, 8'h11};
    start_load(); expect_load(b, 1); send_stream(b, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset_busy", 0, busy_w[0], 0);
    chk("reset_wr_en", 0, wr_en_w[0], 0);
    chk("reset_in_ready", 1, rdy_w[1], 0);
    repeat (2) @(posedge clock);
    #1;

    // load_start while busy is ignored.
    b = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAC};
    start_load(); expect_load(b, 0);
    send_byte(8'h02, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    start_load();
    send_byte(8'h33, 0); send_byte(8'h44, 0); send_byte(8'hAC, 0);
    wait_idle();

    // Three words: the 0xFE instance wraps to 0x00.
    b = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h18};
    start_load(); expect_load(b, 0); send_stream(b, 1); wait_idle();

    // N = 0 means 256 words.
    b = {};
    b.push_back(8'h00);
    sum = 0;
    for (int i = 0; i < 512; i++) begin
      x = 8'($urandom);
      b.push_back(x);
      sum += int'(x);
    end
    b.push_back(8'(sum));
    start_load(); expect_load(b, 0); send_stream(b, 0); wait_idle();
    chk("words_256", 1, ww_w[1], 256);

    // Random loads, some with corrupted checksums.
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 6));
      b = {};
      b.push_back(8'(n));
      sum = n;
      for (int i = 0; i < 2 * n; i++) begin
        x = 8'($urandom);
        b.push_back(x);
        sum += int'(x);
      end
      if (r % 3 == 1) b.push_back(8'(sum + 1));
      else            b.push_back(8'(sum));
      start_load(); expect_load(b, 0); send_stream(b, 3); wait_idle();
    end

    for (int k = 0; k < 2; k++) begin
      chk("writes_left", k, wr_size(k), 0);
      chk("outcomes_left", k, oc_size(k), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
